// File: rtl/enc_cnt_mch.sv
`default_nettype none
// ============================================================================
// Module      : enc_cnt_mch
// Description : Multi-channel encoder timebase capture. Each channel arms on
//               the rising edge of its Z index pulse, then runs a saturating
//               timebase. Every rising edge of its A pulse captures the
//               timebase, strobes O_VLD and counts the capture. With P_REZERO
//               set, each later Z edge rebases the timebase and counts a
//               revolution.
// Ports       : CLK      - system clock, rising edge
//               I_ARM    - asynchronous active-low clear / high to arm
//               I_A      - per-channel asynchronous A pulse
//               I_Z      - per-channel asynchronous Z index pulse
//               O_CNT    - last captured timebase, channel n at [n*P_CNT_W +: P_CNT_W]
//               O_VLD    - one-cycle strobe when a channel's O_CNT updates
//               O_EDGES  - per-channel capture count (wrapping)
//               O_REV    - per-channel rebase count (wrapping)
//               O_OVF    - per-channel sticky timebase saturation flag
//               O_ACTIVE - per-channel ACTIVE state indicator
// Revision    : 1.0 - initial release
// ============================================================================
module enc_cnt_mch #(
    parameter int P_NUM_CH   = 4,
    parameter int P_CNT_W    = 32,
    parameter int P_EDGE_W   = 16,
    parameter int P_REV_W    = 16,
    parameter int P_SYNC_STG = 2,
    parameter int P_REZERO   = 0
) (
    input  logic                         CLK,
    input  logic                         I_ARM,
    input  logic [P_NUM_CH-1:0]          I_A,
    input  logic [P_NUM_CH-1:0]          I_Z,
    output logic [P_NUM_CH*P_CNT_W-1:0]  O_CNT,
    output logic [P_NUM_CH-1:0]          O_VLD,
    output logic [P_NUM_CH*P_EDGE_W-1:0] O_EDGES,
    output logic [P_NUM_CH*P_REV_W-1:0]  O_REV,
    output logic [P_NUM_CH-1:0]          O_OVF,
    output logic [P_NUM_CH-1:0]          O_ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    localparam logic [P_CNT_W-1:0]  TB_MAX   = '1;
    localparam logic [P_CNT_W-1:0]  TB_ONE   = P_CNT_W'(1);
    localparam logic [P_EDGE_W-1:0] EDGE_ONE = P_EDGE_W'(1);
    localparam logic [P_REV_W-1:0]  REV_ONE  = P_REV_W'(1);
    localparam bit                  REZERO_EN = (P_REZERO != 0);

    generate
        for (genvar ch = 0; ch < P_NUM_CH; ch++) begin : g_ch
            logic [P_SYNC_STG-1:0] a_sync;
            logic [P_SYNC_STG-1:0] z_sync;
            logic                  a_s;
            logic                  z_s;
            logic                  a_d;
            logic                  z_d;
            logic                  rise_a;
            logic                  rise_z;

            state_t                state;
            state_t                state_nxt;
            logic [P_CNT_W-1:0]    tb;
            logic [P_CNT_W-1:0]    tb_nxt;
            logic [P_CNT_W-1:0]    cnt;
            logic [P_CNT_W-1:0]    cnt_nxt;
            logic [P_EDGE_W-1:0]   edges;
            logic [P_EDGE_W-1:0]   edges_nxt;
            logic [P_REV_W-1:0]    rev;
            logic [P_REV_W-1:0]    rev_nxt;
            logic                  ovf;
            logic                  ovf_nxt;
            logic                  vld;
            logic                  vld_nxt;

            // Synchronizer chains plus one extra flop for rising-edge detection.
            always_ff @(posedge CLK or negedge I_ARM) begin
                if (!I_ARM) begin
                    a_sync <= '0;
                    z_sync <= '0;
                    a_d    <= 1'b0;
                    z_d    <= 1'b0;
                end else begin
                    a_sync <= {a_sync[P_SYNC_STG-2:0], I_A[ch]};
                    z_sync <= {z_sync[P_SYNC_STG-2:0], I_Z[ch]};
                    a_d    <= a_s;
                    z_d    <= z_s;
                end
            end

            assign a_s    = a_sync[P_SYNC_STG-1];
            assign z_s    = z_sync[P_SYNC_STG-1];
            assign rise_a = a_s & ~a_d;
            assign rise_z = z_s & ~z_d;

            always_ff @(posedge CLK or negedge I_ARM) begin
                if (!I_ARM) begin
                    state <= ST_IDLE;
                end else begin
                    state <= state_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                tb_nxt    = tb;
                cnt_nxt   = cnt;
                vld_nxt   = 1'b0;
                edges_nxt = edges;
                rev_nxt   = rev;
                ovf_nxt   = ovf;
                case (state)
                    ST_IDLE: begin
                        tb_nxt = '0;
                        if (rise_z) begin
                            state_nxt = ST_ACTIVE;
                            tb_nxt    = TB_ONE;
                        end
                    end
                    ST_ACTIVE: begin
                        // Capture uses the pre-increment timebase, so the
                        // count equals the edge distance from Z to A.
                        if (rise_a) begin
                            cnt_nxt   = tb;
                            vld_nxt   = 1'b1;
                            edges_nxt = edges + EDGE_ONE;
                        end
                        // A rebase wins over saturation and leaves OVF alone.
                        if (REZERO_EN && rise_z) begin
                            tb_nxt  = TB_ONE;
                            rev_nxt = rev + REV_ONE;
                        end else if (tb == TB_MAX) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            tb_nxt = tb + TB_ONE;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        tb_nxt    = '0;
                    end
                endcase
            end

            always_ff @(posedge CLK or negedge I_ARM) begin
                if (!I_ARM) begin
                    tb    <= '0;
                    cnt   <= '0;
                    vld   <= 1'b0;
                    edges <= '0;
                    rev   <= '0;
                    ovf   <= 1'b0;
                end else begin
                    tb    <= tb_nxt;
                    cnt   <= cnt_nxt;
                    vld   <= vld_nxt;
                    edges <= edges_nxt;
                    rev   <= rev_nxt;
                    ovf   <= ovf_nxt;
                end
            end

            assign O_CNT[ch*P_CNT_W +: P_CNT_W]    = cnt;
            assign O_VLD[ch]                       = vld;
            assign O_EDGES[ch*P_EDGE_W +: P_EDGE_W] = edges;
            assign O_REV[ch*P_REV_W +: P_REV_W]    = rev;
            assign O_OVF[ch]                       = ovf;
            assign O_ACTIVE[ch]                    = (state == ST_ACTIVE);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_enc_cnt_mch.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_cnt_mch
// Description : Self-checking bench for enc_cnt_mch. Two instances (rebase
//               off / on) share stimulus; a timestamp-based model predicts
//               every output after every clock edge, plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_cnt_mch;

    localparam int NCH   = 2;
    localparam int CW    = 8;
    localparam int EW    = 4;
    localparam int RW    = 4;
    localparam int SS    = 2;
    localparam int TBMAX = 255;
    localparam int HLEN  = 4096;

    logic       CLK   = 1'b0;
    logic       I_ARM = 1'b1;
    logic [1:0] I_A   = 2'b00;
    logic [1:0] I_Z   = 2'b00;

    logic [15:0] cnt0, cnt1;
    logic [1:0]  vld0, vld1;
    logic [7:0]  edg0, edg1;
    logic [7:0]  rev0, rev1;
    logic [1:0]  ovf0, ovf1;
    logic [1:0]  act0, act1;

    always #5 CLK = ~CLK;

    enc_cnt_mch #(
        .P_NUM_CH(NCH), .P_CNT_W(CW), .P_EDGE_W(EW), .P_REV_W(RW),
        .P_SYNC_STG(SS), .P_REZERO(0)
    ) dut0 (
        .CLK(CLK), .I_ARM(I_ARM), .I_A(I_A), .I_Z(I_Z),
        .O_CNT(cnt0), .O_VLD(vld0), .O_EDGES(edg0), .O_REV(rev0),
        .O_OVF(ovf0), .O_ACTIVE(act0)
    );

    enc_cnt_mch #(
        .P_NUM_CH(NCH), .P_CNT_W(CW), .P_EDGE_W(EW), .P_REV_W(RW),
        .P_SYNC_STG(SS), .P_REZERO(1)
    ) dut1 (
        .CLK(CLK), .I_ARM(I_ARM), .I_A(I_A), .I_Z(I_Z),
        .O_CNT(cnt1), .O_VLD(vld1), .O_EDGES(edg1), .O_REV(rev1),
        .O_OVF(ovf1), .O_ACTIVE(act1)
    );

    int checks   = 0;
    int failures = 0;

    // Model: input samples indexed by edge number since arming; an active
    // channel remembers the edge at which its timebase last (re)started, so
    // the timebase before edge m is min(m - start, TBMAX).
    bit samp_a [0:1][0:HLEN-1];
    bit samp_z [0:1][0:HLEN-1];
    int n_edge;
    bit m_act   [0:1][0:1];
    int m_start [0:1][0:1];
    int m_cnt   [0:1][0:1];
    bit m_vld   [0:1][0:1];
    int m_edges [0:1][0:1];
    int m_rev   [0:1][0:1];
    bit m_ovf   [0:1][0:1];

    function automatic bit smp(input bit is_z, input int ch, input int idx);
        if (idx < 0) return 1'b0;
        return is_z ? samp_z[ch][idx] : samp_a[ch][idx];
    endfunction

    task automatic model_reset();
        n_edge = 0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_act[d][c]   = 1'b0;
                m_start[d][c] = 0;
                m_cnt[d][c]   = 0;
                m_vld[d][c]   = 1'b0;
                m_edges[d][c] = 0;
                m_rev[d][c]   = 0;
                m_ovf[d][c]   = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic [1:0] a, input logic [1:0] z);
        bit ra, rz;
        int n;
        n = n_edge;
        for (int c = 0; c < NCH; c++) begin
            samp_a[c][n] = a[c];
            samp_z[c][n] = z[c];
        end
        for (int c = 0; c < NCH; c++) begin
            // A level first sampled at edge j becomes a usable rise at edge j+SS.
            ra = smp(1'b0, c, n - SS) && !smp(1'b0, c, n - SS - 1);
            rz = smp(1'b1, c, n - SS) && !smp(1'b1, c, n - SS - 1);
            for (int d = 0; d < 2; d++) begin
                m_vld[d][c] = 1'b0;
                if (!m_act[d][c]) begin
                    if (rz) begin
                        m_act[d][c]   = 1'b1;
                        m_start[d][c] = n;
                    end
                end else begin
                    if (ra) begin
                        m_cnt[d][c]   = (n - m_start[d][c] > TBMAX) ? TBMAX : n - m_start[d][c];
                        m_vld[d][c]   = 1'b1;
                        m_edges[d][c] = (m_edges[d][c] + 1) % (1 << EW);
                    end
                    if (d == 1 && rz) begin
                        m_start[d][c] = n;
                        m_rev[d][c]   = (m_rev[d][c] + 1) % (1 << RW);
                    end else if (n - m_start[d][c] >= TBMAX) begin
                        m_ovf[d][c] = 1'b1;
                    end
                end
            end
        end
        n_edge = n + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_cnt;
        logic [1:0]  e_vld, e_ovf, e_act;
        logic [7:0]  e_edg, e_rev;
        for (int d = 0; d < 2; d++) begin
            e_cnt = {8'(m_cnt[d][1]), 8'(m_cnt[d][0])};
            e_vld = {m_vld[d][1], m_vld[d][0]};
            e_ovf = {m_ovf[d][1], m_ovf[d][0]};
            e_act = {m_act[d][1], m_act[d][0]};
            e_edg = {4'(m_edges[d][1]), 4'(m_edges[d][0])};
            e_rev = {4'(m_rev[d][1]), 4'(m_rev[d][0])};
            chk($sformatf("m_d%0d_cnt", d),   (d == 0) ? cnt0 : cnt1, e_cnt);
            chk($sformatf("m_d%0d_vld", d),   (d == 0) ? vld0 : vld1, e_vld);
            chk($sformatf("m_d%0d_edges", d), (d == 0) ? edg0 : edg1, e_edg);
            chk($sformatf("m_d%0d_rev", d),   (d == 0) ? rev0 : rev1, e_rev);
            chk($sformatf("m_d%0d_ovf", d),   (d == 0) ? ovf0 : ovf1, e_ovf);
            chk($sformatf("m_d%0d_active", d), (d == 0) ? act0 : act1, e_act);
        end
    endtask

    // Drive inputs between edges, take one edge, check 1 time unit later.
    task automatic step(input logic [1:0] a, input logic [1:0] z);
        I_A = a;
        I_Z = z;
        @(posedge CLK);
        if (I_ARM) model_edge(a, z);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00);
    endtask

    task automatic do_reset();
        I_ARM = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) step(2'($urandom), 2'($urandom));
        I_A   = 2'b00;
        I_Z   = 2'b00;
        I_ARM = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        // Cleared while held low, whatever the inputs do.
        I_ARM = 1'b0;
        #1;
        chk("rst_cnt0", cnt0, 16'h0);
        chk("rst_act1", act1, 2'b00);
        for (int i = 0; i < 4; i++) step(2'($urandom), 2'($urandom));
        I_A   = 2'b00;
        I_Z   = 2'b00;
        I_ARM = 1'b1;

        // A in IDLE is ignored.
        step(2'b01, 2'b00); idle(1); step(2'b01, 2'b00); idle(3);
        chk("idle_vld0", vld0[0], 1'b0);
        chk("idle_edges0", edg0[3:0], 4'd0);
        chk("idle_active0", act0[0], 1'b0);

        // Z at edge k, A at k+10 -> capture 10 visible after k+12.
        step(2'b00, 2'b01);
        idle(9);
        step(2'b01, 2'b00);
        idle(1);
        chk("lat_vld_early", vld0[0], 1'b0);
        idle(1);
        chk("lat_vld0", vld0[0], 1'b1);
        chk("lat_cnt0", cnt0[7:0], 8'd10);
        chk("lat_edges0", edg0[3:0], 4'd1);
        chk("lat_ch1_cnt", cnt0[15:8], 8'd0);
        chk("lat_ch1_vld", vld0[1], 1'b0);
        idle(1);
        chk("lat_vld0_drop", vld0[0], 1'b0);
        chk("lat_cnt0_hold", cnt0[7:0], 8'd10);

        // Saturation and sticky overflow.
        do_reset();
        step(2'b00, 2'b01);
        idle(299);
        step(2'b01, 2'b00);
        idle(2);
        chk("sat_cnt0", cnt0[7:0], 8'd255);
        chk("sat_ovf0", ovf0[0], 1'b1);
        idle(47);
        step(2'b01, 2'b00);
        idle(2);
        chk("sat2_cnt0", cnt0[7:0], 8'd255);
        chk("sat2_edges0", edg0[3:0], 4'd2);
        chk("sat2_ovf1_rz", ovf1[0], 1'b1);

        // Rebase on second Z (dut1), ignored by dut0.
        do_reset();
        step(2'b00, 2'b01);
        idle(19);
        step(2'b00, 2'b01);
        idle(4);
        step(2'b01, 2'b00);
        idle(2);
        chk("rz_cnt_d1", cnt1[7:0], 8'd5);
        chk("rz_rev_d1", rev1[3:0], 4'd1);
        chk("rz_cnt_d0", cnt0[7:0], 8'd25);
        chk("rz_rev_d0", rev0[3:0], 4'd0);
        idle(12);
        step(2'b01, 2'b01);
        idle(2);
        chk("rz_same_cnt_d1", cnt1[7:0], 8'd20);
        chk("rz_same_rev_d1", rev1[3:0], 4'd2);
        chk("rz_same_cnt_d0", cnt0[7:0], 8'd40);
        idle(7);
        step(2'b01, 2'b00);
        idle(2);
        chk("rz_after_cnt_d1", cnt1[7:0], 8'd10);
        chk("rz_after_cnt_d0", cnt0[7:0], 8'd50);

        // Two channels, simultaneous captures.
        do_reset();
        step(2'b00, 2'b01);
        idle(2);
        step(2'b00, 2'b10);
        idle(3);
        step(2'b11, 2'b00);
        idle(2);
        chk("mc_cnt_ch0", cnt0[7:0], 8'd7);
        chk("mc_cnt_ch1", cnt0[15:8], 8'd4);
        chk("mc_vld", vld0, 2'b11);

        // Asynchronous clear between edges, then no capture without a new Z.
        do_reset();
        step(2'b00, 2'b01);
        step(2'b01, 2'b00);
        idle(20);
        #2;
        I_ARM = 1'b0;
        model_reset();
        #1;
        chk("async_cnt0", cnt0, 16'h0);
        chk("async_act0", act0, 2'b00);
        chk("async_edges0", edg0, 8'h0);
        check_all();
        for (int i = 0; i < 3; i++) step(2'($urandom), 2'($urandom));
        I_A   = 2'b00;
        I_Z   = 2'b00;
        I_ARM = 1'b1;
        step(2'b01, 2'b00);
        idle(3);
        chk("rearm_vld0", vld0[0], 1'b0);
        chk("rearm_edges0", edg0[3:0], 4'd0);
        chk("rearm_act0", act0[0], 1'b0);

        // Random traffic against the model, with periodic re-arming.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] ra, rz;
            if (i % 400 == 399) do_reset();
            ra = 2'($urandom);
            rz[0] = ($urandom_range(0, 19) == 0);
            rz[1] = ($urandom_range(0, 19) == 0);
            step(ra, rz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
